// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath it steers.
// The controller takes the master side: it reads decode/status inputs and drives every mux and strobe.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             funct3_0;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             ir_write;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             instr_done;
  logic [CNT_W-1:0] retired_cnt;
  logic             illegal_op;

  modport master (
    input  op, funct3_0, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           instr_done, retired_cnt, illegal_op
  );

  modport slave (
    output op, funct3_0, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           instr_done, retired_cnt, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RISC-V sequencer: steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory
// and ALU, stalls on mem_ready, flags undefined opcodes and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  logic       pc_write_s, adr_src_s, ir_write_s, mem_write_s, reg_write_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;
  logic       instr_done_s, illegal_dec_s;

  // Immediate format follows the opcode directly, independent of sequencing state.
  always_comb begin
    case (bus.op)
      OP_LOAD, OP_I: imm_src_s = 2'b00;
      OP_STORE:      imm_src_s = 2'b01;
      OP_BR:         imm_src_s = 2'b10;
      OP_JAL:        imm_src_s = 2'b11;
      default:       imm_src_s = 2'b00;
    endcase
  end

  // Next-state and datapath controls, decoded from the current state and live status inputs.
  always_comb begin
    state_d       = state_q;
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    ir_write_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    alu_op_s      = 2'b00;
    instr_done_s  = 1'b0;
    illegal_dec_s = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC+imm so branch/jump targets are ready for the next state.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal_dec_s = 1'b1;
            if (ILLEGAL_HALT) begin
              state_d = S_HALT;
            end else begin
              instr_done_s = 1'b1;
              state_d      = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (bus.op == OP_LOAD) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXEC_R: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        pc_write_s   = bus.zero ^ bus.funct3_0;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Sequencer state, retired-instruction counter and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_done_s) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (illegal_dec_s) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign bus.pc_write    = pc_write_s;
  assign bus.adr_src     = adr_src_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.mem_write   = mem_write_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.result_src  = result_src_s;
  assign bus.alu_src_a   = alu_src_a_s;
  assign bus.alu_src_b   = alu_src_b_s;
  assign bus.alu_op      = alu_op_s;
  assign bus.imm_src     = imm_src_s;
  assign bus.instr_done  = instr_done_s;
  assign bus.retired_cnt = retired_q;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench: per-cycle expected control vectors are queued as each instruction is
// set up, then popped and compared while the sequencer walks through its states.
module tb_multicycle_ctrl_fsm;

  localparam int CW = 4;

  typedef struct packed {
    logic       pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       instr_done, illegal_op;
  } out_t;

  typedef struct packed {
    logic mem_ready;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_fsm_if #(.CNT_W(CW)) bus ();

  multicycle_ctrl_fsm #(.CNT_W(CW), .ILLEGAL_HALT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t        vq[$];
  string       tq[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [1:0]  imm_cur;
  logic        ill_cur;
  logic [CW-1:0] exp_cnt;

  function automatic out_t mk(input logic pcw, input logic adr, input logic irw, input logic mw,
                              input logic rw, input logic [1:0] res, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop, input logic done);
    out_t o;
    o.pc_write = pcw; o.adr_src = adr; o.ir_write = irw; o.mem_write = mw; o.reg_write = rw;
    o.result_src = res; o.alu_src_a = a; o.alu_src_b = b; o.alu_op = aop;
    o.imm_src = imm_cur; o.instr_done = done; o.illegal_op = ill_cur;
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.pc_write = bus.pc_write; o.adr_src = bus.adr_src; o.ir_write = bus.ir_write;
    o.mem_write = bus.mem_write; o.reg_write = bus.reg_write; o.result_src = bus.result_src;
    o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.imm_src = bus.imm_src; o.instr_done = bus.instr_done; o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check_out(input string tag, input out_t e);
    out_t o;
    o = observed();
    n_vec++;
    assert (o === e) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_bit(input string tag, input logic o, input logic e);
    n_vec++;
    assert (o === e) else begin
      n_miss++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] e);
    n_vec++;
    assert (bus.retired_cnt === e) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus.retired_cnt, e);
    end
  endtask

  task automatic push(input logic rdy, input out_t e, input string tag);
    vec_t v;
    v.mem_ready = rdy;
    v.exp = e;
    vq.push_back(v);
    tq.push_back(tag);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic f3, input logic z);
    bus.op = op; bus.funct3_0 = f3; bus.zero = z;
    imm_cur = imm_of(op);
  endtask

  task automatic push_fetch(input int w);
    for (int i = 0; i < w; i++)
      push(1'b0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), "fetch_wait");
    push(1'b1, mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), "fetch");
  endtask

  task automatic push_decode();
    push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), "decode");
  endtask

  task automatic push_aluwb();
    push(rnd(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1), "aluwb");
  endtask

  // Drive each queued vector for one cycle: inputs after negedge, sample 1 ns later.
  task automatic run();
    vec_t  v;
    string t;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      t = tq.pop_front();
      bus.mem_ready = v.mem_ready;
      #1;
      check_out(t, v.exp);
      @(negedge clk);
    end
  endtask

  task automatic exec(input logic [6:0] op, input logic f3, input logic z, input int fw, input int mw);
    set_instr(op, f3, z);
    push_fetch(fw);
    push_decode();
    case (op)
      7'b0110011: begin
        push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0), "exec_r");
        push_aluwb();
      end
      7'b0010011: begin
        push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0), "exec_i");
        push_aluwb();
      end
      7'b0000011: begin
        push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), "memadr");
        for (int i = 0; i < mw; i++)
          push(1'b0, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memread_wait");
        push(1'b1, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memread");
        push(rnd(), mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1), "memwb");
      end
      7'b0100011: begin
        push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), "memadr");
        for (int i = 0; i < mw; i++)
          push(1'b0, mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memwrite_wait");
        push(1'b1, mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), "memwrite");
      end
      7'b1100011:
        push(rnd(), mk(z ^ f3, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1), "branch");
      7'b1101111: begin
        push(rnd(), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0), "jal");
        push_aluwb();
      end
      default: ;
    endcase
    run();
    exp_cnt++;
    check_cnt("retired_cnt", exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = 7'd0; bus.funct3_0 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    imm_cur = 2'b00; ill_cur = 1'b0; exp_cnt = {CW{1'b0}};

    repeat (2) @(negedge clk);
    #1;
    check_out("reset_outputs", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    check_cnt("reset_cnt", exp_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "reset_state");

    exec(7'b0110011, 1'b0, 1'b0, 0, 0);   // R-type
    exec(7'b0000011, 1'b0, 1'b0, 0, 3);   // lw, 3 wait cycles
    exec(7'b0100011, 1'b0, 1'b0, 0, 2);   // sw, 2 wait cycles
    exec(7'b0010011, 1'b0, 1'b0, 0, 0);   // I-type
    exec(7'b1101111, 1'b0, 1'b0, 0, 0);   // jal
    exec(7'b1100011, 1'b0, 1'b1, 0, 0);   // beq taken
    exec(7'b1100011, 1'b1, 1'b1, 0, 0);   // bne not taken
    exec(7'b1100011, 1'b0, 1'b0, 0, 0);   // beq not taken
    exec(7'b1100011, 1'b1, 1'b0, 0, 0);   // bne taken
    exec(7'b0110011, 1'b0, 1'b0, 2, 0);   // fetch stall
    for (int k = 0; k < 6; k++)
      exec(7'b1100011, k[0], 1'b1, 0, 0);
    check_cnt("cnt_wrapped", 4'd0);

    // Abort a store while it is still waiting on memory.
    set_instr(7'b0100011, 1'b0, 1'b0);
    push_fetch(0);
    push_decode();
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), "memadr");
    push(1'b0, mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memwrite_wait");
    push(1'b0, mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "memwrite_wait");
    run();
    bus.mem_ready = 1'b0;
    #1;
    check_bit("pre_abort_mem_write", bus.mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("abort_mem_write", bus.mem_write, 1'b0);
    check_bit("abort_pc_write", bus.pc_write, 1'b0);
    check_bit("abort_instr_done", bus.instr_done, 1'b0);
    exp_cnt = {CW{1'b0}};
    check_cnt("abort_cnt", exp_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    set_instr(7'b0110011, 1'b0, 1'b0);
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "reset_state");
    exec(7'b0110011, 1'b0, 1'b0, 0, 0);

    // Undefined opcode parks the sequencer in HALT.
    set_instr(7'b1111111, 1'b0, 1'b0);
    push_fetch(0);
    push_decode();
    ill_cur = 1'b1;
    for (int i = 0; i < 20; i++)
      push(rnd(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "halt");
    run();
    check_cnt("halt_cnt", exp_cnt);
    rst_n = 1'b0;
    #1;
    check_bit("illegal_cleared", bus.illegal_op, 1'b0);
    ill_cur = 1'b0;
    exp_cnt = {CW{1'b0}};
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), "reset_state");
    exec(7'b0000011, 1'b0, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
